fnd_scan_ctrl: RTL
==================

# fnd_scan_ctrl

Time-multiplexed scan controller for the stopwatch's 4-digit common-anode FND. It takes a 16-bit packed BCD value (4 digits). Each digit is driven in turn onto the shared segment bus by producing the active-low digit-common lines and the 4-bit code consumed directly by `bcd_to_seg`. The block provides:

- frame-coherent snapshotting;
- optional leading-zero blanking;
- a dark gap between digits to suppress ghosting.

## Interface
Parameters:
- `REFRESH_DIV`, default 100_000 — cycles each digit is lit (1 ms at 100 MHz); must be ≥ 1.
- `GAP_CYCLES`, default 1_000 — cycles all digits are dark between digits; must be ≥ 1.

Ports:
- `clk`  in  1  system clock. Single clock domain; reset is asynchronous, active-low.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable; 0 forces display dark.
- `value`  in  16  packed BCD; `[3:0]` = digit 0 (rightmost), `[15:12]` = digit 3.
- `lz_blank`  in  1  1 = blank leading zeros.
- `com`  out  4  active-low digit commons; bit i lights digit i.
- `bcd_out`  out  4  code to `bcd_to_seg`; 4'hF = all segments off.
- `digit_idx`  out  2  index of the digit currently selected.
- `frame_tick`  out  1  one-cycle pulse when a new frame snapshot is taken.

## Operation
State machine, two states: `GAP`, `SHOW`. It uses one counter `cnt` (width `$clog2(max(REFRESH_DIV, GAP_CYCLES))`), an index `idx`, and snapshot registers `snap_value`/`snap_lz`.

`GAP` state:
- Outputs: `com` = 4'b1111, `bcd_out` = 4'hF.
- `cnt` counts 0..`GAP_CYCLES`-1.
- At terminal count, move to `SHOW` with `cnt` cleared.
- If `idx` == 0 on that transition, load `snap_value` ← `value` and `snap_lz` ← `lz_blank`, and assert `frame_tick` for one cycle. This cycle is the GAP→SHOW edge.

`SHOW` state:
- Outputs: `com` = ~(4'b0001 << `idx`), `bcd_out` = displayed code of digit `idx` from the snapshot.
- `cnt` counts 0..`REFRESH_DIV`-1.
- At terminal count, move to `GAP`, set `idx` ← `idx`+1 (mod 4, wrapping 3→0), and clear `cnt`.

Digit values and blanking:
- Digit codes A–F pass through unchanged and count as non-zero.
- The live `value` is never displayed directly. Changes mid-frame become visible only at the next `frame_tick`.

Leading-zero blanking (only when `snap_lz` = 1):
- Digit 3 is blanked if it is 0.
- Digit 2 is blanked if digits 3 and 2 are both 0.
- Digit 1 is blanked if digits 3, 2 and 1 are all 0.
- Digit 0 is never blanked.
- A blanked digit outputs 4'hF while its `com` bit is still driven low.

`en` = 0:
- The next cycle goes to `GAP` with `idx` = 0 and `cnt` = 0. It holds there (counter frozen at 0) while `en` = 0; `frame_tick` stays 0.
- On `en` rising, a full `GAP_CYCLES` dark period runs, then digit 0 shows with a fresh snapshot.

## Timing
- All outputs are registered.
- Reset values:
  - `com` = 4'b1111, `bcd_out` = 4'hF, `digit_idx` = 0, `frame_tick` = 0
  - state `GAP`, `cnt` = 0
  - `snap_value` = 16'h0000, `snap_lz` = 0
- The first `SHOW` (digit 0) begins `GAP_CYCLES` cycles after reset release, provided `en` = 1.
- `com` and `bcd_out` change in the same cycle, so `com` is never low while `bcd_out` belongs to a different digit.
- Full frame period = 4 × (`REFRESH_DIV` + `GAP_CYCLES`) cycles; `frame_tick` has exactly this period while `en` = 1.
- `value` to display latency: up to one frame plus `GAP_CYCLES`.
- If `en` falls on the same cycle as a terminal count, `en` wins: go to `GAP`, `idx` = 0.
- Reset asserted mid-operation: every output returns to its reset value immediately (asynchronously).

## Structure
- Shared package `fnd_pkg` holds:
  - the state enum (`GAP`, `SHOW`);
  - constants `FND_BLANK` = 4'hF, `FND_DOT` = 4'hE, `COM_OFF` = 4'b1111;
  - function `lz_mask(value)` → 4-bit blank mask, reused by other FND users.
- No sub-module. The parent `fnd_cntr` instantiates `fnd_scan_ctrl` and `bcd_to_seg` side by side, wiring `bcd_out` to `bcd`.

## Test plan
Benches use `REFRESH_DIV` = 4, `GAP_CYCLES` = 2 unless stated.
- Reset/idle: hold `reset_n` = 0 → `com` = 4'b1111, `bcd_out` = F; after release, first `com` = 4'b1110 with `bcd_out` = digit 0 exactly 2 cycles later.
- Scan order: `value` = 16'h1234, `lz_blank` = 0 → digits 0..3 show 4, 3, 2, 1, each for 4 cycles with `com` = E, D, B, 7, separated by 2 dark cycles; `frame_tick` period = 24 cycles.
- Blanking: `value` = 16'h0005, `lz_blank` = 1 → digit 0 = 5, digits 1–3 = F. `value` = 16'h0000 → digit 0 = 0, others F. `value` = 16'h0105 → digit 1 shows 0 (not blanked).
- Snapshot: change `value` 16'h1234 → 16'h5678 during digit 1 `SHOW` → digits 2 and 3 still show 2 and 1; the new value appears after the next `frame_tick`.
- Enable: drop `en` during digit 2 `SHOW` → `com` = 4'b1111 next cycle, `frame_tick` silent. Raise `en` → 2 dark cycles, then digit 0 with a fresh snapshot.
- Async reset mid-`SHOW` of digit 3 → outputs return to reset values within the same cycle (before the next `clk` edge); the scan restarts at digit 0.

Source files
------------

// File: rtl/fnd_pkg.sv
// ---------------------------------------------------------------------------
// fnd_pkg
// Shared definitions for the 4-digit common-anode FND display path.
//   scan_state_t : scan controller states (GAP = all digits dark, SHOW = one
//                  digit lit)
//   FND_BLANK    : code understood by bcd_to_seg as "all segments off"
//   FND_DOT      : code understood by bcd_to_seg as "decimal point only"
//   COM_OFF      : active-low commons with every digit disabled
//   lz_mask()    : per-digit leading-zero blank mask for a packed BCD word
// ---------------------------------------------------------------------------
package fnd_pkg;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_t;

    localparam logic [3:0] FND_BLANK = 4'hF;
    localparam logic [3:0] FND_DOT   = 4'hE;
    localparam logic [3:0] COM_OFF   = 4'b1111;

    // Bit i set means digit i is a leading zero and should be blanked.
    // Digit 0 is never blanked so a value of zero still shows "0".
    // Codes A-F count as non-zero.
    function automatic logic [3:0] lz_mask(input logic [15:0] value);
        logic [3:0] mask;
        mask[3] = (value[15:12] == 4'h0);
        mask[2] = mask[3] && (value[11:8] == 4'h0);
        mask[1] = mask[2] && (value[7:4] == 4'h0);
        mask[0] = 1'b0;
        return mask;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// fnd_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode FND. Digits are
// lit one at a time for REFRESH_DIV cycles, separated by GAP_CYCLES dark
// cycles to suppress ghosting. The displayed value is snapshotted once per
// frame (on entry to digit 0) so a frame never mixes two input values.
//
// Parameters
//   REFRESH_DIV : cycles each digit is lit (>= 1)
//   GAP_CYCLES  : dark cycles between digits (>= 1)
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   en         in   scan enable; 0 forces the display dark and restarts scan
//   value      in   packed BCD, [3:0] = digit 0 (rightmost)
//   lz_blank   in   1 = blank leading zeros
//   com        out  active-low digit commons, bit i lights digit i
//   bcd_out    out  code for bcd_to_seg, 4'hF = segments off
//   digit_idx  out  index of the digit currently selected
//   frame_tick out  one-cycle pulse when a new snapshot is taken
// ---------------------------------------------------------------------------
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int GAP_CYCLES  = 1_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [15:0] value,
    input  logic        lz_blank,
    output logic [3:0]  com,
    output logic [3:0]  bcd_out,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      snap_value_q, snap_value_d;
    logic             snap_lz_q, snap_lz_d;
    logic [3:0]       com_q, com_d;
    logic [3:0]       bcd_out_q, bcd_out_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic             frame_tick_q, frame_tick_d;

    logic [3:0]       blank_mask;
    logic [3:0]       digit_code;

    // Next-state logic for the scan sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_value_d = snap_value_q;
        snap_lz_d    = snap_lz_q;
        frame_tick_d = 1'b0;

        if (!en) begin
            // Disable overrides any terminal count in the same cycle.
            state_d = GAP;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else begin
            unique case (state_q)
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        if (idx_q == 2'd0) begin
                            snap_value_d = value;
                            snap_lz_d    = lz_blank;
                            frame_tick_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = GAP;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are derived from the *next* state so that, once registered,
    // they line up exactly with the state register. com and bcd_out are
    // produced from the same idx_d and therefore always switch together.
    always_comb begin
        blank_mask  = lz_mask(snap_value_d);
        digit_code  = snap_value_d[{idx_d, 2'b00} +: 4];
        digit_idx_d = idx_d;
        if (state_d == SHOW) begin
            com_d     = ~(4'b0001 << idx_d);
            bcd_out_d = (snap_lz_d && blank_mask[idx_d]) ? FND_BLANK : digit_code;
        end else begin
            com_d     = COM_OFF;
            bcd_out_d = FND_BLANK;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= GAP;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            snap_value_q <= 16'h0000;
            snap_lz_q    <= 1'b0;
            com_q        <= COM_OFF;
            bcd_out_q    <= FND_BLANK;
            digit_idx_q  <= 2'd0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_value_q <= snap_value_d;
            snap_lz_q    <= snap_lz_d;
            com_q        <= com_d;
            bcd_out_q    <= bcd_out_d;
            digit_idx_q  <= digit_idx_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign com        = com_q;
    assign bcd_out    = bcd_out_q;
    assign digit_idx  = digit_idx_q;
    assign frame_tick = frame_tick_q;

endmodule
